// File: rtl/branch_pkg.sv
// Shared branch definitions: RV32I branch funct3 codes, BHT counter encoding and saturating helpers.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    function automatic bht_ctr_t sat_inc(input bht_ctr_t c);
        logic [1:0] v;
        v = c;
        return (c == ST) ? ST : bht_ctr_t'(v + 2'd1);
    endfunction

    function automatic bht_ctr_t sat_dec(input bht_ctr_t c);
        logic [1:0] v;
        v = c;
        return (c == SNT) ? SNT : bht_ctr_t'(v - 2'd1);
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational RV32I branch condition evaluation; legal flags the six defined funct3 codes.
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            branch,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            taken,
    output logic            legal
);

    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic                   cond;

    assign sa = operand_a;
    assign sb = operand_b;

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  cond = (operand_a == operand_b);
            F3_BNE:  cond = (operand_a != operand_b);
            F3_BLT:  cond = (sa < sb);
            F3_BGE:  cond = !(sa < sb);
            F3_BLTU: cond = (operand_a < operand_b);
            F3_BGEU: cond = !(operand_a < operand_b);
            default: legal = 1'b0;
        endcase
        taken = branch & cond;
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// BHT-based branch predictor with EX-side resolve, training and registered redirect.
// Optional BRANCH_STATS_EN adds resolve/mispredict event counters.
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_branch,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_operand_a,
    input  logic [XLEN-1:0] ex_operand_b,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            ex_taken,
`ifdef BRANCH_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
`endif
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bht_ctr_t        bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       if_ctr;
    logic             legal;
    logic             resolve;
    logic             mis_next;
    logic             unused_if_pc;

    assign if_idx        = if_pc[IDX_W+1:2];
    assign ex_idx        = ex_pc[IDX_W+1:2];
    assign if_ctr        = bht[if_idx];
    assign if_pred_taken = if_valid & if_ctr[1];
    assign unused_if_pc  = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    branch_compare #(
        .XLEN (XLEN)
    ) u_compare (
        .branch    (ex_branch),
        .funct3    (ex_funct3),
        .operand_a (ex_operand_a),
        .operand_b (ex_operand_b),
        .taken     (ex_taken),
        .legal     (legal)
    );

    // While a redirect is pulsing, the instruction in EX is wrong-path and must be squashed.
    assign resolve  = ex_valid & ex_branch & ~ex_stall & ~mispredict & legal;
    assign mis_next = resolve & (ex_taken != ex_pred_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= WNT;
            end
        end else if (resolve) begin
            bht[ex_idx] <= ex_taken ? sat_inc(bht[ex_idx]) : sat_dec(bht[ex_idx]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= mis_next;
            if (mis_next) begin
                redirect_pc <= ex_taken ? ex_target : ex_pc + XLEN'(4);
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed-vector bench for branch_predict_resolve with hand-computed expectations.
module tb_branch_predict_resolve;
    import branch_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            ex_valid;
    logic            ex_stall;
    logic            ex_branch;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_operand_a;
    logic [XLEN-1:0] ex_operand_b;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            ex_taken;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predict_resolve #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_branch        (ex_branch),
        .ex_funct3        (ex_funct3),
        .ex_operand_a     (ex_operand_a),
        .ex_operand_b     (ex_operand_b),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_taken         (ex_taken),
`ifdef BRANCH_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [XLEN-1:0] pc, input logic exp);
        if_valid = 1'b1;
        if_pc    = pc;
        #1;
        chk(tag, {63'd0, if_pred_taken}, {63'd0, exp});
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt, input logic pred);
        ex_valid      = 1'b1;
        ex_branch     = 1'b1;
        ex_funct3     = f3;
        ex_operand_a  = a;
        ex_operand_b  = b;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        #1;
    endtask

    task automatic idle_ex();
        ex_valid  = 1'b0;
        ex_branch = 1'b0;
        ex_stall  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; ex_stall = 1'b0;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_funct3 = '0; ex_operand_a = '0;
        ex_operand_b = '0; ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // 1: reset state
        chk("rst_mispredict", {63'd0, mispredict}, 64'd0);
        chk("rst_redirect", {32'd0, redirect_pc}, 64'd0);
        for (int i = 0; i < 64; i++) lookup("rst_lookup", XLEN'(i * 4), 1'b0);
        lookup("rst_lookup_100", 32'h100, 1'b0);
        if_valid = 1'b0; if_pc = 32'h40; #1;
        chk("no_valid_pred", {63'd0, if_pred_taken}, 64'd0);

        // 2: BEQ taken, predicted not taken
        drive_br(F3_BEQ, 32'd5, 32'd5, 32'h40, 32'h80, 1'b0);
        chk("beq_taken", {63'd0, ex_taken}, 64'd1);
        lookup("same_cycle_pre", 32'h40, 1'b0);
        step(); idle_ex(); #1;
        chk("beq_mis", {63'd0, mispredict}, 64'd1);
        chk("beq_redirect", {32'd0, redirect_pc}, 64'h80);
        lookup("beq_wt", 32'h40, 1'b1);
        step();
        chk("beq_mis_clear", {63'd0, mispredict}, 64'd0);
        drive_br(F3_BEQ, 32'd5, 32'd5, 32'h40, 32'h80, 1'b1);
        step(); idle_ex(); #1;
        chk("beq2_nomis", {63'd0, mispredict}, 64'd0);
        // ST -> WT via one not-taken; still predicts taken
        drive_br(F3_BNE, 32'd5, 32'd5, 32'h40, 32'h80, 1'b1);
        chk("bne_nt", {63'd0, ex_taken}, 64'd0);
        step(); idle_ex(); #1;
        chk("bne_mis", {63'd0, mispredict}, 64'd1);
        chk("bne_redirect", {32'd0, redirect_pc}, 64'h44);
        lookup("st_then_wt", 32'h40, 1'b1);
        step();

        // 3: signed/unsigned compares, per-index training
        drive_br(F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h80, 32'h100, 1'b1);
        chk("blt_taken", {63'd0, ex_taken}, 64'd1);
        step(); idle_ex(); #1;
        chk("blt_nomis", {63'd0, mispredict}, 64'd0);
        lookup("blt_idx", 32'h80, 1'b1);
        drive_br(F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h84, 32'h100, 1'b0);
        chk("bltu_nt", {63'd0, ex_taken}, 64'd0);
        step(); idle_ex(); #1;
        chk("bltu_nomis", {63'd0, mispredict}, 64'd0);
        lookup("bltu_idx", 32'h84, 1'b0);
        drive_br(F3_BGEU, 32'd7, 32'd7, 32'h88, 32'h200, 1'b0);
        chk("bgeu_taken", {63'd0, ex_taken}, 64'd1);
        step(); idle_ex(); #1;
        chk("bgeu_mis", {63'd0, mispredict}, 64'd1);
        chk("bgeu_redirect", {32'd0, redirect_pc}, 64'h200);
        lookup("bgeu_idx", 32'h88, 1'b1);
        lookup("neighbor_idx", 32'h8C, 1'b0);
        step();
        ex_valid = 1'b0; ex_branch = 1'b1; ex_funct3 = F3_BGE;
        ex_operand_a = 32'hFFFF_FFFF; ex_operand_b = 32'd1; #1;
        chk("bge_nt", {63'd0, ex_taken}, 64'd0);
        ex_operand_a = 32'd1; ex_operand_b = 32'hFFFF_FFFF; #1;
        chk("bge_taken", {63'd0, ex_taken}, 64'd1);
        ex_branch = 1'b0; #1;
        chk("nonbranch_taken", {63'd0, ex_taken}, 64'd0);

        // 4: branch right after a mispredict is squashed
        drive_br(F3_BEQ, 32'd1, 32'd1, 32'hC0, 32'h300, 1'b0);
        step();
        drive_br(F3_BEQ, 32'd1, 32'd1, 32'hC4, 32'h304, 1'b0);
        chk("squash_mis1", {63'd0, mispredict}, 64'd1);
        step(); idle_ex(); #1;
        chk("squash_nomis", {63'd0, mispredict}, 64'd0);
        lookup("squash_untrained", 32'hC4, 1'b0);

        // 5: stall holds a mispredicting branch
        drive_br(F3_BEQ, 32'd2, 32'd2, 32'hD0, 32'h400, 1'b0);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_nomis", {63'd0, mispredict}, 64'd0);
        end
        lookup("stall_untrained", 32'hD0, 1'b0);
        ex_stall = 1'b0;
        step(); idle_ex(); #1;
        chk("unstall_mis", {63'd0, mispredict}, 64'd1);
        chk("unstall_redirect", {32'd0, redirect_pc}, 64'h400);
        step();
        drive_br(3'b010, 32'd2, 32'd2, 32'hD4, 32'h500, 1'b1);
        chk("illegal_taken", {63'd0, ex_taken}, 64'd0);
        step(); idle_ex(); #1;
        chk("illegal_nomis", {63'd0, mispredict}, 64'd0);
        lookup("illegal_untrained", 32'hD4, 1'b0);

        // 6: saturation at SNT, PC wrap, reset mid-pulse
        for (int i = 0; i < 5; i++) begin
            drive_br(F3_BNE, 32'd9, 32'd9, 32'hE0, 32'h600, 1'b0);
            step();
        end
        idle_ex(); #1;
        chk("sat_nomis", {63'd0, mispredict}, 64'd0);
        drive_br(F3_BEQ, 32'd9, 32'd9, 32'hE0, 32'h600, 1'b0);
        step(); idle_ex(); #1;
        lookup("sat_snt_to_wnt", 32'hE0, 1'b0);
        step();
        drive_br(F3_BEQ, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h700, 1'b1);
        step(); idle_ex(); #1;
        chk("wrap_mis", {63'd0, mispredict}, 64'd1);
        chk("wrap_redirect", {32'd0, redirect_pc}, 64'h0);
        step();
        drive_br(F3_BEQ, 32'd3, 32'd3, 32'hF0, 32'h800, 1'b0);
        step(); idle_ex(); #1;
        chk("pre_rst_mis", {63'd0, mispredict}, 64'd1);
        #2 rst_n = 1'b0; #1;
        chk("rst_mid_mis", {63'd0, mispredict}, 64'd0);
        chk("rst_mid_redirect", {32'd0, redirect_pc}, 64'h0);
        lookup("rst_lost_training", 32'h40, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_mis", {63'd0, mispredict}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
